noc_inject_arbiter: RTL
=======================

// Module: noc_inject_arbiter
// PURPOSE
//  - Shares one NoC injection port among NUM_REQ flit sources: scheduler, mapper and reducer outputs.
//  - Arbitration is round-robin at packet granularity. A winner keeps the port until its
//    end-of-packet flit is accepted, so packets are never interleaved.
//  - Sits between the flit producers and the local router input buffer.
// PARAMETERS
//  NUM_REQ     4             number of requesters (2..8)
//  FLIT_W      36            flit width: [35:4] payload, [3:0] route address
//  END_WORD    32'hFFFFFFFF  payload value that marks the last flit of a packet
//  STAT_W      16            width of per-port packet counters (ARB_STATS_EN only)
// PORTS
//  clk             in   1               rising-edge clock
//  reset           in   1               synchronous, active-high reset
//  req_valid       in   NUM_REQ         requester i has a flit on req_data slice i
//  req_data        in   NUM_REQ*FLIT_W  flits; slice i = [i*FLIT_W +: FLIT_W]
//  req_ready       out  NUM_REQ         flit i is accepted this cycle when valid & ready
//  out_ready       in   1               router buffer not full
//  out_valid       out  1               out_data holds a flit
//  out_data        out  FLIT_W          registered flit toward the router
//  out_grant       out  NUM_REQ         one-hot current owner; 0 when IDLE
//  busy            out  1               FSM in BUSY
//  stat_sel        in   $clog2(NUM_REQ) counter select (ARB_STATS_EN only)
//  stat_pkt_count  out  STAT_W          packets completed by port stat_sel (ARB_STATS_EN only)
// BEHAVIOUR
//  - Reset: out_valid=0, out_data=0, out_grant=0, busy=0, req_ready=0.
//    Round-robin pointer = NUM_REQ-1, so port 0 has first priority. Counters are cleared.
//  - FSM IDLE -> BUSY when |req_valid:
//      - Winner is the first valid port searching upward from ptr+1, modulo NUM_REQ.
//      - out_grant is registered and becomes valid the next cycle (1-cycle arbitration latency).
//      - req_ready is 0 for every port while IDLE.
//  - FSM BUSY:
//      - req_ready[g] = out_grant[g] & (!out_valid | out_ready); all other bits are 0.
//      - An accepted flit loads out_data and sets out_valid on the next edge
//        (accept-to-output latency 1 cycle).
//      - out_valid clears after a cycle with out_valid & out_ready & no new accept.
//  - End of packet: an accepted flit with payload [35:4]==END_WORD causes, on the same edge:
//      - ptr <= g, out_grant <= 0, FSM -> IDLE.
//      - The next arbitration starts the following cycle.
//      - Minimum packet gap on the port is therefore 1 idle accept cycle.
//  - A single-flit packet (first flit == END_WORD) is legal and takes 1 accept cycle.
//  - Owner drops req_valid mid-packet: the grant is held and the port stalls. No timeout.
//  - Non-owner valids are ignored while BUSY. Their flits must stay stable (valid/ready rules).
//  - Backpressure: with out_ready=0 and out_valid=1, req_ready=0.
//    out_data is held stable until consumed.
//  - Route address [3:0] passes through untouched. The arbiter never decodes it.
//  - Reset asserted mid-packet: the packet is dropped, all state returns to reset values,
//    and the pointer returns to NUM_REQ-1.
// CONFIGURATION
//  - Macro ARB_STATS_EN defined:
//      - Per-port STAT_W-bit counter increments on each accepted END_WORD flit.
//      - The counter saturates at all-ones.
//      - stat_pkt_count = count[stat_sel], combinational mux of registered counters.
//  - Macro ARB_STATS_EN undefined: the counters are not built, stat_sel is ignored,
//    and stat_pkt_count is tied to 0.
// STRUCTURE
//  - Package noc_pkg holds:
//      - FLIT_W, PAYLOAD_W=32, ADDR_W=4, END_WORD.
//      - typedef flit_t {payload, route}.
//      - arbiter state enum {ARB_IDLE, ARB_BUSY}.
//  - Sub-module rr_pick:
//      - Purely combinational.
//      - Inputs: req vector and pointer. Output: one-hot winner plus a found flag.
//      - Reusable by later reducer-side arbiters.
//  - Top level holds the FSM, grant register, output register and the optional stats.
// TESTING
//  1. After reset, req_valid=4'b1111, each port sends 1-flit END_WORD packets:
//     grants go 0,1,2,3,0.
//  2. Port 2 sends 3 flits (A, B, FFFFFFFF) while port 1 is valid throughout:
//     out_data = A, B, FFFFFFFF with no port 1 flit between them; port 1 is granted next.
//  3. out_ready held 0 for 5 cycles mid-packet: out_data is stable,
//     req_ready[g]=0, and no flit is lost or duplicated.
//  4. Owner deasserts valid for 3 cycles mid-packet while port 0 is valid:
//     out_grant is unchanged and port 0 gets no req_ready.
//  5. Reset pulsed during a packet from port 3:
//     the next cycle shows out_valid=0 and out_grant=0; a new request is granted to port 0 first.
//  6. ARB_STATS_EN defined, 3 packets from port 1, stat_sel=1: stat_pkt_count=3.
//     ARB_STATS_EN undefined: stat_pkt_count=0.

Source files
------------

// File: rtl/noc_pkg.sv
// Shared NoC flit definitions and arbiter state encoding.
package noc_pkg;

   localparam int FLIT_W    = 36;
   localparam int PAYLOAD_W = 32;
   localparam int ADDR_W    = 4;
   localparam logic [PAYLOAD_W-1:0] END_WORD = 32'hFFFF_FFFF;

   typedef struct packed {
      logic [PAYLOAD_W-1:0] payload;
      logic [ADDR_W-1:0]    route;
   } flit_t;

   typedef enum logic {
      ARB_IDLE,
      ARB_BUSY
   } arb_state_e;

endpackage

// File: rtl/noc_inject_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request searching upward from ptr+1.
module rr_pick #(
   parameter int N     = 4,
   parameter int PTR_W = $clog2(N)
) (
   input  logic [N-1:0]     req,
   input  logic [PTR_W-1:0] ptr,
   output logic [N-1:0]     grant,
   output logic             found
);

   logic [PTR_W-1:0] idx;

   always_comb begin
      grant = '0;
      found = 1'b0;
      idx   = '0;
      for (int unsigned i = 1; i <= N; i++) begin
         idx = PTR_W'((32'(ptr) + i) % N);
         if (!found && req[idx]) begin
            grant[idx] = 1'b1;
            found      = 1'b1;
         end
      end
   end

endmodule

// File: rtl/noc_inject_arbiter.sv
// Packet-granular round-robin injection arbiter in front of the local router.
// Optional per-port packet counters are built when ARB_STATS_EN is defined.
module noc_inject_arbiter #(
   parameter int          NUM_REQ  = 4,
   parameter int          FLIT_W   = 36,
   parameter logic [31:0] END_WORD = 32'hFFFF_FFFF,
   parameter int          STAT_W   = 16
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic [NUM_REQ-1:0]           req_valid,
   input  logic [NUM_REQ*FLIT_W-1:0]    req_data,
   output logic [NUM_REQ-1:0]           req_ready,
   input  logic                         out_ready,
   output logic                         out_valid,
   output logic [FLIT_W-1:0]            out_data,
   output logic [NUM_REQ-1:0]           out_grant,
   output logic                         busy,
   input  logic [$clog2(NUM_REQ)-1:0]   stat_sel,
   output logic [STAT_W-1:0]            stat_pkt_count
);

   import noc_pkg::*;

   localparam int PTR_W = $clog2(NUM_REQ);

   arb_state_e         state_q, state_d;
   logic [PTR_W-1:0]   ptr_q, ptr_d;
   logic [NUM_REQ-1:0] grant_q, grant_d;
   logic               out_valid_q, out_valid_d;
   flit_t              out_data_q, out_data_d;

   logic [NUM_REQ-1:0] pick_grant;
   logic               pick_found;
   logic [FLIT_W-1:0]  sel_raw;
   flit_t              sel_flit;
   logic [PTR_W-1:0]   gidx;
   logic               accept;
   logic               eop;

   rr_pick #(
      .N     (NUM_REQ),
      .PTR_W (PTR_W)
   ) u_rr_pick (
      .req   (req_valid),
      .ptr   (ptr_q),
      .grant (pick_grant),
      .found (pick_found)
   );

   always_comb begin
      sel_raw = '0;
      gidx    = '0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         if (grant_q[i]) begin
            sel_raw = req_data[i*FLIT_W +: FLIT_W];
            gidx    = PTR_W'(i);
         end
      end
   end

   assign sel_flit  = sel_raw;
   assign req_ready = (state_q == ARB_BUSY && (!out_valid_q || out_ready)) ? grant_q : '0;
   assign accept    = |(req_valid & req_ready);
   assign eop       = accept && (sel_flit.payload == END_WORD);

   always_comb begin
      state_d     = state_q;
      ptr_d       = ptr_q;
      grant_d     = grant_q;
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;

      // Output register drains independently of the FSM so a last flit can leave while IDLE.
      if (accept) begin
         out_data_d  = sel_flit;
         out_valid_d = 1'b1;
      end else if (out_ready) begin
         out_valid_d = 1'b0;
      end

      case (state_q)
         ARB_IDLE: begin
            if (pick_found) begin
               grant_d = pick_grant;
               state_d = ARB_BUSY;
            end
         end
         ARB_BUSY: begin
            if (eop) begin
               ptr_d   = gidx;
               grant_d = '0;
               state_d = ARB_IDLE;
            end
         end
         default: state_d = ARB_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= ARB_IDLE;
         ptr_q       <= PTR_W'(NUM_REQ - 1);
         grant_q     <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
      end else begin
         state_q     <= state_d;
         ptr_q       <= ptr_d;
         grant_q     <= grant_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
      end
   end

   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_grant = grant_q;
   assign busy      = (state_q == ARB_BUSY);

`ifdef ARB_STATS_EN
   logic [STAT_W-1:0] cnt_q [NUM_REQ];
   logic [STAT_W-1:0] cnt_d [NUM_REQ];

   always_comb begin
      cnt_d = cnt_q;
      if (eop && cnt_q[gidx] != '1) begin
         cnt_d[gidx] = cnt_q[gidx] + STAT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int unsigned i = 0; i < NUM_REQ; i++) begin
            cnt_q[i] <= '0;
         end
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign stat_pkt_count = (32'(stat_sel) < NUM_REQ) ? cnt_q[stat_sel] : '0;
`else
   logic unused_stat_sel;
   assign unused_stat_sel = ^stat_sel;
   assign stat_pkt_count  = '0;
`endif

endmodule
